// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA transfer sequencer.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } dma_state_e;

  function automatic int unsigned DMA_BEAT_BYTES(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable bus address counter; advances by one beat per accepted beat when
// the increment mode latched at load time is set.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc_cfg,
  input  logic          advance,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] STEP = AW'(DMA_BEAT_BYTES(DW));

  logic inc_mode;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr     <= '0;
      inc_mode <= 1'b0;
    end else if (load) begin
      addr     <= load_addr;
      inc_mode <= inc_cfg;
    end else if (advance && inc_mode) begin
      addr <= addr + STEP;  // wraps silently modulo 2^AW
    end
  end

endmodule

// File: rtl/dma_xfer_seq.sv
// Single-channel DMA transfer sequencer: bus read -> channel FIFO -> bus write.
// Optional error handling (rd_err/wr_err/err) is compiled in with DMA_XFER_ERR_EN.
module dma_xfer_seq
  import dma_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LEN_W   = 16,
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    cfg_src,
  input  logic [AW-1:0]    cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_src_inc,
  input  logic             cfg_dst_inc,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             rd_req,
  input  logic             rd_ack,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             fifo_wr,
  output logic [DW-1:0]    fifo_wdata,
  output logic             fifo_rd,
  input  logic [DW-1:0]    fifo_rdata
`ifdef DMA_XFER_ERR_EN
  ,
  input  logic             rd_err,
  input  logic             wr_err,
  output logic             err
`endif
);

  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  dma_state_e       state;
  logic [LEN_W-1:0] rd_left;
  logic [LEN_W-1:0] wr_left;
  logic [FIFO_AW:0] level;
  logic             abort_pend;
  logic             rd_hold;
  logic             wr_hold;

  logic run;
  logic launch;
  logic rd_hs;
  logic wr_hs;
  logic push;
  logic pop;
  logic err_hit;
  logic last_wr;

  assign run    = (state == ST_RUN);
  assign launch = (state == ST_IDLE) && start && (cfg_len != '0);

  // NOTE: a raised request is kept alive by its hold flag, so a late abort never withdraws it mid-handshake.
  assign rd_req = run && (rd_hold || ((rd_left != '0) && (level < DEPTH_L) && !abort_pend));
  assign wr_req = run && (wr_hold || ((wr_left != '0) && (level != '0) && !abort_pend));

  assign rd_hs = rd_req && rd_ack;
  assign wr_hs = wr_req && wr_ack;

`ifdef DMA_XFER_ERR_EN
  assign err_hit = (rd_hs && rd_err) || (wr_hs && wr_err);
  assign push    = rd_hs && !rd_err;
`else
  assign err_hit = 1'b0;
  assign push    = rd_hs;
`endif

  assign pop     = wr_hs || ((state == ST_FLUSH) && (level != '0));
  assign last_wr = wr_hs && (wr_left == LEN_ONE);

  assign fifo_wr    = push;
  assign fifo_wdata = rd_data;
  assign fifo_rd    = pop;
  assign wr_data    = fifo_rdata;

  dma_addr_gen #(.AW(AW), .DW(DW)) u_src_addr (
    .clk       (clk),
    .resetn    (resetn),
    .load      (launch),
    .load_addr (cfg_src),
    .inc_cfg   (cfg_src_inc),
    .advance   (rd_hs),
    .addr      (rd_addr)
  );

  dma_addr_gen #(.AW(AW), .DW(DW)) u_dst_addr (
    .clk       (clk),
    .resetn    (resetn),
    .load      (launch),
    .load_addr (cfg_dst),
    .inc_cfg   (cfg_dst_inc),
    .advance   (wr_hs),
    .addr      (wr_addr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      rd_hold    <= 1'b0;
      wr_hold    <= 1'b0;
      rd_left    <= '0;
      wr_left    <= '0;
      level      <= '0;
`ifdef DMA_XFER_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      rd_hold <= rd_req && !rd_ack;
      wr_hold <= wr_req && !wr_ack;

      // Occupancy mirrors the FIFO; simultaneous push and pop cancel out.
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase

      if (rd_hs) rd_left <= rd_left - LEN_ONE;
      if (wr_hs) wr_left <= wr_left - LEN_ONE;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            aborted <= 1'b0;
`ifdef DMA_XFER_ERR_EN
            err     <= 1'b0;
`endif
            if (cfg_len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              busy       <= 1'b1;
              rd_left    <= cfg_len;
              wr_left    <= cfg_len;
              abort_pend <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (abort || err_hit) abort_pend <= 1'b1;
`ifdef DMA_XFER_ERR_EN
          if (err_hit) err <= 1'b1;
`endif
          if (last_wr) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
            if (err_hit) aborted <= 1'b1;
          end else if (abort_pend && !rd_req && !wr_req) begin
            state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (level == '0) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_seq.sv
// Randomized bench for dma_xfer_seq with a bus responder, a FIFO model and a
// beat-list reference; define DMA_XFER_ERR_EN to also cover error handling.
`timescale 1ns/1ps
module tb_dma_xfer_seq;

  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        cfg_src_inc, cfg_dst_inc;
  logic        busy, done, aborted;
  logic        rd_req, rd_ack, wr_req, wr_ack;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic        fifo_wr, fifo_rd;
  logic [31:0] fifo_wdata, fifo_rdata;
`ifdef DMA_XFER_ERR_EN
  logic        rd_err, wr_err, err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] seed;
  int rd_limit, wr_after, rd_stall_pct, wr_stall_pct, abort_on_wr, err_on_wr;
  bit wr_stall;

  logic [31:0] obs_rd_addr[$];
  logic [31:0] obs_wr_addr[$];
  logic [31:0] obs_wr_data[$];
  int rd_bonus;

  dma_xfer_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc),
    .busy(busy), .done(done), .aborted(aborted),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata)
`ifdef DMA_XFER_ERR_EN
    , .rd_err(rd_err), .wr_err(wr_err), .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Source memory contents as a function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ seed;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic inc, input int i);
    return inc ? base + 32'(i * BB) : base;
  endfunction

  // Reference: beat i reads src+i*BB (or src) and writes that word to dst+i*BB (or dst).
  function automatic int bad_reads(input int n);
    if (obs_rd_addr.size() != n) return -2;
    for (int i = 0; i < n; i++)
      if (obs_rd_addr[i] !== exp_addr(cfg_src, cfg_src_inc, i)) return i;
    return -1;
  endfunction

  function automatic int bad_writes(input int n);
    if (obs_wr_addr.size() != n) return -2;
    for (int i = 0; i < n; i++)
      if (obs_wr_addr[i] !== exp_addr(cfg_dst, cfg_dst_inc, i) ||
          obs_wr_data[i] !== mem_fn(exp_addr(cfg_src, cfg_src_inc, i))) return i;
    return -1;
  endfunction

  // Bus responder: acks are decided on the falling edge, handshakes complete on the rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      rd_ack = 1'b0; wr_ack = 1'b0; abort = 1'b0; rd_data = '0; rd_bonus = 0;
`ifdef DMA_XFER_ERR_EN
      rd_err = 1'b0; wr_err = 1'b0;
`endif
    end else begin
      if (start) begin
        obs_rd_addr.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
        rd_bonus = 0;
      end
      rd_ack = rd_req && (rd_limit < 0 || obs_rd_addr.size() < rd_limit + rd_bonus) &&
               (int'($urandom_range(99)) >= rd_stall_pct);
      if (rd_ack) begin
        rd_data = mem_fn(rd_addr);
        obs_rd_addr.push_back(rd_addr);
      end
      wr_ack = wr_req && !wr_stall && obs_rd_addr.size() >= wr_after &&
               (int'($urandom_range(99)) >= wr_stall_pct);
      abort = 1'b0;
      if (wr_ack) begin
        obs_wr_addr.push_back(wr_addr);
        obs_wr_data.push_back(wr_data);
        if (obs_wr_addr.size() == abort_on_wr) begin
          abort = 1'b1;
          rd_bonus = 1;
        end
      end
`ifdef DMA_XFER_ERR_EN
      wr_err = wr_ack && (obs_wr_addr.size() == err_on_wr);
`endif
    end
  end

  // Channel FIFO model, depth 8, with underflow/overflow and flush-pop counters.
  logic [31:0] fmem [0:7];
  logic [2:0]  fw, fr;
  int fcnt, unf, ovf, flush_pops;
  assign fifo_rdata = fmem[fr];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fw <= '0; fr <= '0; fcnt <= 0; flush_pops <= 0;
    end else begin
      if (start) flush_pops <= 0;
      else if (fifo_rd && !(wr_req && wr_ack)) flush_pops <= flush_pops + 1;
      if (fifo_rd && fcnt == 0) unf <= unf + 1;
      if (fifo_wr && fcnt == 8 && !fifo_rd) ovf <= ovf + 1;
      if (fifo_wr) begin
        fmem[fw] <= fifo_wdata;
        fw <= fw + 3'd1;
      end
      if (fifo_rd && fcnt != 0) fr <= fr + 3'd1;
      fcnt <= fcnt + (fifo_wr ? 1 : 0) - ((fifo_rd && fcnt != 0) ? 1 : 0);
    end
  end

  task automatic set_bus(input int rp, input int wp);
    rd_stall_pct = rp; wr_stall_pct = wp;
    rd_limit = -1; wr_after = 0; wr_stall = 1'b0; abort_on_wr = 0; err_on_wr = 0;
  endtask

  task automatic do_start(input int len, input logic [31:0] s, input logic [31:0] d,
                          input logic si, input logic di);
    @(posedge clk); #1;
    cfg_len = 16'(len); cfg_src = s; cfg_dst = d;
    cfg_src_inc = si; cfg_dst_inc = di; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 0 is the start cycle; returns the cycle in which done is seen.
  task automatic wait_done(input int budget, output int cyc, output bit timed_out);
    cyc = 0; timed_out = 1'b1;
    while (cyc < budget) begin
      cyc++;
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, aborted, rd_req, wr_req, fifo_wr, fifo_rd} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, done, aborted, rd_req, wr_req, fifo_wr, fifo_rd});
    end
    checks++;
    if (rd_addr !== 32'h0 || wr_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got rd %h wr %h expected 0", rd_addr, wr_addr);
    end
    checks++;
    if (wr_data !== fifo_rdata) begin
      failures++;
      $display("FAIL reset_wr_data: got %h expected fifo head %h", wr_data, fifo_rdata);
    end
`ifdef DMA_XFER_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b expected 0", err);
    end
`endif
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy %b rd_req %b expected 0 0", busy, rd_req);
    end
  endtask

  task automatic test_basic();
    int cyc, r; bit to;
    set_bus(0, 0);
    do_start(4, 32'h1000, 32'h2000, 1'b1, 1'b1);
    wait_done(50, cyc, to);
    checks++;
    if (to || cyc != 6) begin
      failures++;
      $display("FAIL basic_latency: done in cycle %0d (timeout %0b) expected 6", cyc, to);
    end
    r = bad_reads(4);
    checks++;
    if (r != -1) begin
      failures++;
      $display("FAIL basic_reads: bad beat %0d, %0d reads, expected 4 from 0x1000", r, obs_rd_addr.size());
    end
    r = bad_writes(4);
    checks++;
    if (r != -1) begin
      failures++;
      $display("FAIL basic_writes: bad beat %0d, %0d writes, expected 4 to 0x2000", r, obs_wr_addr.size());
    end
    checks++;
    if (aborted !== 1'b0 || fcnt != 0) begin
      failures++;
      $display("FAIL basic_end: aborted %b fifo %0d expected 0 0", aborted, fcnt);
    end
  endtask

  task automatic test_zero_len();
    set_bus(0, 0);
    do_start(0, 32'h500, 32'h600, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({done, busy, rd_req, wr_req} !== 4'b1000) begin
      failures++;
      $display("FAIL zero_len_cycle1: done/busy/rd/wr %b expected 1000", {done, busy, rd_req, wr_req});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, rd_req, wr_req} !== 4'b0000 || obs_rd_addr.size() != 0) begin
      failures++;
      $display("FAIL zero_len_cycle2: done/busy/rd/wr %b reads %0d expected 0000 0",
               {done, busy, rd_req, wr_req}, obs_rd_addr.size());
    end
  endtask

  task automatic test_wrap();
    int cyc, r; bit to;
    logic [31:0] a2;
    set_bus(0, 0);
    do_start(3, 32'hFFFF_FFF8, 32'h0000_3000, 1'b1, 1'b0);
    wait_done(50, cyc, to);
    r = bad_reads(3);
    checks++;
    if (to || r != -1) begin
      failures++;
      $display("FAIL wrap_reads: bad beat %0d, %0d reads, timeout %0b", r, obs_rd_addr.size(), to);
    end
    a2 = (obs_rd_addr.size() > 2) ? obs_rd_addr[2] : 32'hDEAD_BEEF;
    checks++;
    if (a2 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_third_addr: got %h expected 00000000", a2);
    end
    r = bad_writes(3);
    checks++;
    if (r != -1) begin
      failures++;
      $display("FAIL wrap_writes: bad beat %0d, %0d writes, expected 3 to 0x3000", r, obs_wr_addr.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc, r; bit to;
    set_bus(0, 0);
    wr_stall = 1'b1;
    do_start(20, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 1'b1, 1'b1);
    repeat (15) @(negedge clk);
    #1;
    checks++;
    if (obs_rd_addr.size() != 8 || rd_req !== 1'b0 || obs_wr_addr.size() != 0) begin
      failures++;
      $display("FAIL bp_fill: reads %0d rd_req %b writes %0d expected 8 0 0",
               obs_rd_addr.size(), rd_req, obs_wr_addr.size());
    end
    wr_stall = 1'b0;
    wait_done(300, cyc, to);
    r = bad_reads(20);
    checks++;
    if (to || r != -1) begin
      failures++;
      $display("FAIL bp_reads: bad beat %0d, %0d reads expected 20, timeout %0b", r, obs_rd_addr.size(), to);
    end
    r = bad_writes(20);
    checks++;
    if (r != -1 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL bp_writes: bad beat %0d, %0d writes expected 20, aborted %b", r, obs_wr_addr.size(), aborted);
    end
  endtask

  task automatic test_abort();
    int cyc, r, w; bit to;
    set_bus(0, 0);
    rd_limit = 5; wr_after = 5; abort_on_wr = 2;
    do_start(10, 32'h0000_8000, 32'h0000_9000, 1'b1, 1'b1);
    wait_done(100, cyc, to);
    checks++;
    if (to || aborted !== 1'b1) begin
      failures++;
      $display("FAIL abort_done: aborted %b timeout %0b expected 1 0", aborted, to);
    end
    r = bad_reads(6);
    w = bad_writes(2);
    checks++;
    if (r != -1 || w != -1) begin
      failures++;
      $display("FAIL abort_beats: reads %0d (bad %0d) writes %0d (bad %0d) expected 6 2",
               obs_rd_addr.size(), r, obs_wr_addr.size(), w);
    end
    checks++;
    if (flush_pops != 4 || fcnt != 0) begin
      failures++;
      $display("FAIL abort_flush: popped %0d left %0d expected 4 0", flush_pops, fcnt);
    end
    set_bus(0, 0);
  endtask

`ifdef DMA_XFER_ERR_EN
  task automatic test_err();
    int cyc, w; bit to;
    set_bus(0, 0);
    err_on_wr = 3;
    do_start(8, 32'h0000_4000, 32'h0000_5000, 1'b1, 1'b1);
    wait_done(100, cyc, to);
    w = bad_writes(3);
    checks++;
    if (to || err !== 1'b1 || aborted !== 1'b1 || w != -1 || fcnt != 0) begin
      failures++;
      $display("FAIL err_flush: err %b aborted %b writes %0d fifo %0d timeout %0b expected 1 1 3 0 0",
               err, aborted, obs_wr_addr.size(), fcnt, to);
    end
    set_bus(0, 0);
    do_start(2, 32'h0000_4000, 32'h0000_5000, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_clear: err %b busy %b expected 0 1", err, busy);
    end
    wait_done(50, cyc, to);
    checks++;
    if (to || err !== 1'b0 || aborted !== 1'b0 || bad_writes(2) != -1) begin
      failures++;
      $display("FAIL err_next_xfer: err %b aborted %b writes %0d expected 0 0 2", err, aborted, obs_wr_addr.size());
    end
  endtask
`endif

  task automatic test_random();
    int cyc, len, r, w; bit to;
    for (int t = 0; t < 6; t++) begin
      set_bus(int'($urandom_range(60)), int'($urandom_range(60)));
      len = int'($urandom_range(24, 1));
      do_start(len, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               1'($urandom_range(1)), 1'($urandom_range(1)));
      wait_done(1500, cyc, to);
      r = bad_reads(len);
      w = bad_writes(len);
      checks++;
      if (to || r != -1 || w != -1) begin
        failures++;
        $display("FAIL random_%0d: len %0d reads %0d (bad %0d) writes %0d (bad %0d) timeout %0b",
                 t, len, obs_rd_addr.size(), r, obs_wr_addr.size(), w, to);
      end
      checks++;
      if (aborted !== 1'b0 || fcnt != 0) begin
        failures++;
        $display("FAIL random_%0d_end: aborted %b fifo %0d expected 0 0", t, aborted, fcnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    set_bus(0, 0);
    wr_stall = 1'b1;
    do_start(16, 32'h0000_A000, 32'h0000_B000, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_req, wr_req, fifo_wr, fifo_rd} !== 6'b0 || rd_addr !== 32'h0 || wr_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: flags %b rd %h wr %h expected 0 0 0",
               {busy, done, rd_req, wr_req, fifo_wr, fifo_rd}, rd_addr, wr_addr);
    end
    @(posedge clk); #1 resetn = 1'b1;
    set_bus(0, 0);
    do_start(3, 32'h0000_C000, 32'h0000_D000, 1'b1, 1'b1);
    wait_done(50, cyc, to);
    checks++;
    if (to || cyc != 5 || bad_writes(3) != -1) begin
      failures++;
      $display("FAIL after_reset_xfer: done cycle %0d writes %0d expected 5 3", cyc, obs_wr_addr.size());
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0;
    unf = 0; ovf = 0;
    seed = $urandom;
    set_bus(0, 0);
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_abort();
`ifdef DMA_XFER_ERR_EN
    test_err();
`endif
    test_random();
    test_reset_mid();
    checks++;
    if (unf != 0 || ovf != 0) begin
      failures++;
      $display("FAIL fifo_integrity: underflows %0d overflows %0d expected 0 0", unf, ovf);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_xfer_seq.md
# dma_xfer_seq

Single-channel DMA transfer sequencer for the Cortex-M3 DMA engine. Moves `cfg_len` beats from a source address to a destination address: it drives a bus read port, pushes returned beats into the shared channel FIFO, and pops them to a bus write port. It owns all FIFO push/pop decisions and keeps its own occupancy count, so it never depends on the FIFO's status flags.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; beat size is DW/8 bytes.
- `LEN_W`, 16: transfer length counter width, in beats.
- `FIFO_AW`, 3: log2 of the FIFO depth; DEPTH = 2^FIFO_AW.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch pulse; sampled only in IDLE.
- `abort`  in  1  request to stop the transfer; sampled in RUN.
- `cfg_src`, `cfg_dst`  in  AW  start addresses, latched on `start`.
- `cfg_len`  in  LEN_W  beat count, latched on `start`.
- `cfg_src_inc`, `cfg_dst_inc`  in  1  1 = increment the address per beat, 0 = fixed address.
- `busy`  out  1  high when not in IDLE.
- `done`  out  1  one-cycle pulse when a transfer finishes or is aborted.
- `aborted`  out  1  sticky; set when the last transfer ended by abort or error; cleared on `start`.
- `rd_req`  out  1  read request; `rd_ack`  in  1  read accept with data valid.
- `rd_addr`  out  AW;  `rd_data`  in  DW.
- `wr_req`  out  1  write request; `wr_ack`  in  1  write accept.
- `wr_addr`  out  AW;  `wr_data`  out  DW.
- `fifo_wr`  out  1;  `fifo_wdata`  out  DW;  `fifo_rd`  out  1;  `fifo_rdata`  in  DW (head entry, combinational).
- `rd_err`, `wr_err`  in  1;  `err`  out  1  (present only with DMA_XFER_ERR_EN).

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - `start` with `cfg_len` != 0: latch the configuration, set `rd_left` = `wr_left` = `cfg_len`, clear `aborted`/`err`, go to RUN.
  - `start` with `cfg_len` == 0: `done` pulses next cycle and the block stays in IDLE.
- Read side, in RUN:
  - `rd_req` = (`rd_left` != 0) & (`level` < DEPTH) & ~abort_pending.
  - Once raised, `rd_req` and `rd_addr` hold until `rd_ack`.
  - On `rd_ack`: `fifo_wr` = 1 and `fifo_wdata` = `rd_data` in the same cycle; `rd_left`--; `rd_addr` += DW/8 if `cfg_src_inc` is set.
- Write side, in RUN:
  - `wr_req` = (`wr_left` != 0) & (`level` != 0) & ~abort_pending.
  - `wr_data` = `fifo_rdata`; `wr_req`, `wr_addr` and `wr_data` hold until `wr_ack`.
  - On `wr_ack`: `fifo_rd` = 1; `wr_left`--; `wr_addr` += DW/8 if `cfg_dst_inc` is set.
- `level` (FIFO_AW+1 bits): +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. It never exceeds DEPTH and never underflows.
- Completion: the `wr_ack` that brings `wr_left` to 0 → IDLE, with `done` pulsing the following cycle.
- Abort:
  - `abort` in RUN sets abort_pending. No new request is raised after that.
  - A request already high completes its handshake normally.
  - With no request pending → FLUSH.
  - FLUSH: `fifo_rd` = 1 each cycle while `level` != 0, discarding entries. When `level` == 0 → IDLE, `done` pulses and `aborted` is set.
- Address arithmetic: modulo 2^AW; wrap-around is silent.
- Reset mid-operation: all state returns to its reset values. The FIFO shares `resetn`, so `level` = 0 stays consistent with it.

## Timing
- Reset values:
  - State IDLE; `busy`, `done`, `aborted`, `err`, `rd_req`, `wr_req`, `fifo_wr`, `fifo_rd` = 0.
  - `rd_addr`, `wr_addr` = 0; `wr_data` follows `fifo_rdata`.
- `start` → `rd_req` high at the next cycle.
- `rd_ack` → `wr_req` high at the next cycle when the FIFO was empty (`level` is registered).
- With zero-wait acks on both sides: a sustained throughput of 1 beat per cycle.
- Latency for N beats, zero-wait: the final `wr_ack` occurs in cycle N+1 after `start`; `done` pulses in cycle N+2.
- `fifo_wr` and `fifo_rd` are combinational from `*_req & *_ack`.

## Configuration
- `DMA_XFER_ERR_EN` defined:
  - `rd_err`/`wr_err` are sampled together with `rd_ack`/`wr_ack`.
  - An errored read beat is not pushed.
  - Either error behaves like `abort` and also sets sticky `err`, cleared on `start`.
- `DMA_XFER_ERR_EN` undefined: the `rd_err`, `wr_err` and `err` ports are absent, and error handling logic is removed.

## Structure
- `dma_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH);
  - the `DMA_BEAT_BYTES` constant function of DW.
- Sub-module `dma_addr_gen`: loadable address counter with an increment enable. Instantiated twice, once for source and once for destination.
- The FIFO is instantiated alongside this block by the channel top level, not inside it.

## Test plan
- `cfg_len`=4, src=0x1000, dst=0x2000, inc both, zero-wait acks → reads 0x1000..0x100C, writes 0x2000..0x200C in order, data preserved; `done` at cycle 6.
- `cfg_len`=20, DEPTH=8, `wr_ack` held low for 15 cycles → exactly 8 reads are accepted, then `rd_req` stays low; the transfer completes intact after writes resume.
- `cfg_len`=0 → no `rd_req`/`wr_req`; `done` one cycle after `start`; `busy` stays 0.
- `cfg_dst_inc`=0, src=0xFFFF_FFF8, `cfg_len`=3 → read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; all writes go to dst.
- `cfg_len`=10, `abort` after 5 reads/2 writes, with a read pending → the pending read completes, FLUSH pops the remaining 4 entries, `done` pulses with `aborted`=1.
- With `DMA_XFER_ERR_EN`: `wr_err` on the 3rd write → `err`=1 and flush as abort; the next `start` clears `err`.
